// File: rtl/line_drawer_arbiter.sv
// line_drawer_arbiter: round-robin share of one line drawer between two one-entry command slots
module line_drawer_arbiter #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_WIDTH-1:0] req0_x1,
  input  logic [Y_WIDTH-1:0] req0_y1,
  input  logic [X_WIDTH-1:0] req0_x2,
  input  logic [Y_WIDTH-1:0] req0_y2,
  input  logic               req0_start,
  output logic               req0_ready,
  input  logic [X_WIDTH-1:0] req1_x1,
  input  logic [Y_WIDTH-1:0] req1_y1,
  input  logic [X_WIDTH-1:0] req1_x2,
  input  logic [Y_WIDTH-1:0] req1_y2,
  input  logic               req1_start,
  output logic               req1_ready,
  output logic [X_WIDTH-1:0] x1,
  output logic [Y_WIDTH-1:0] y1,
  output logic [X_WIDTH-1:0] x2,
  output logic [Y_WIDTH-1:0] y2,
  output logic               line_drawer_start,
  input  logic               line_drawer_ready,
  output logic               grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_1, WAIT_2} state_t;
  state_t state, state_next;
  logic [1:0] pending, armed, elig;
  logic last_grant, sel, load, done;
  logic [X_WIDTH-1:0] s_x1 [2];
  logic [X_WIDTH-1:0] s_x2 [2];
  logic [Y_WIDTH-1:0] s_y1 [2];
  logic [Y_WIDTH-1:0] s_y2 [2];
  logic cap0, cap1;
  assign cap0 = req0_start & ~pending[0];
  assign cap1 = req1_start & ~pending[1];
  assign req0_ready = ~pending[0];
  assign req1_ready = ~pending[1];
  // a slot becomes eligible one cycle after its pending flag is set
  assign elig = pending & armed;
  assign sel = &elig ? ~last_grant : elig[1];
  assign line_drawer_start = state == ISSUE;
  // next state: pick a slot in IDLE, pulse, guard cycle, then wait for the drawer
  always_comb begin
    state_next = state;
    load = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (|elig) begin
        load = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: state_next = WAIT_1;
      WAIT_1: state_next = WAIT_2;
      WAIT_2: if (line_drawer_ready) begin
        done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  // slot contents are only read while pending, so they need no reset
  always_ff @(posedge clk) begin
    if (cap0) begin
      s_x1[0] <= req0_x1;
      s_y1[0] <= req0_y1;
      s_x2[0] <= req0_x2;
      s_y2[0] <= req0_y2;
    end
    if (cap1) begin
      s_x1[1] <= req1_x1;
      s_y1[1] <= req1_y1;
      s_x2[1] <= req1_x2;
      s_y2[1] <= req1_y2;
    end
  end
  // pending flags, round-robin history and the registered drawer command
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 2'b00;
      armed <= 2'b00;
      last_grant <= 1'b1;
      grant <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      x2 <= '0;
      y2 <= '0;
    end else begin
      armed <= pending;
      if (cap0) pending[0] <= 1'b1;
      if (cap1) pending[1] <= 1'b1;
      if (done) begin
        pending[grant] <= 1'b0;
        last_grant <= grant;
      end
      if (load) begin
        grant <= sel;
        x1 <= s_x1[sel];
        y1 <= s_y1[sel];
        x2 <= s_x2[sel];
        y2 <= s_y2[sel];
      end
    end
  end
endmodule

// File: tb/tb_line_drawer_arbiter.sv
// tb_line_drawer_arbiter: randomized self-checking bench against an edge-timed reference model
module tb_line_drawer_arbiter;
  logic clk = 0, rst = 0;
  logic [9:0] req0_x1 = 0, req0_x2 = 0, req1_x1 = 0, req1_x2 = 0, x1, x2;
  logic [8:0] req0_y1 = 0, req0_y2 = 0, req1_y1 = 0, req1_y2 = 0, y1, y2;
  logic req0_start = 0, req1_start = 0, req0_ready, req1_ready;
  logic line_drawer_start, line_drawer_ready = 1, grant;
  logic [41:0] obs, expv;
  int checks = 0, errors = 0, n = 0, dhold = 2, dcnt = 0;
  bit mp [2];
  int mcap [2];
  logic [9:0] mx1 [2];
  logic [9:0] mx2 [2];
  logic [8:0] my1 [2];
  logic [8:0] my2 [2];
  bit mbusy;
  int mcur, missue, mlast;
  logic [9:0] ex1, ex2;
  logic [8:0] ey1, ey2;
  logic eg;

  line_drawer_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_x1(req0_x1), .req0_y1(req0_y1), .req0_x2(req0_x2), .req0_y2(req0_y2),
    .req0_start(req0_start), .req0_ready(req0_ready),
    .req1_x1(req1_x1), .req1_y1(req1_y1), .req1_x2(req1_x2), .req1_y2(req1_y2),
    .req1_start(req1_start), .req1_ready(req1_ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .line_drawer_start(line_drawer_start), .line_drawer_ready(line_drawer_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;
  assign obs = {line_drawer_start, req1_ready, req0_ready, grant, x1, y1, x2, y2};

  task automatic drive(int i, int a, int b, int c, int d);
    if (i == 0) begin
      req0_start = 1; req0_x1 = 10'(a); req0_y1 = 9'(b); req0_x2 = 10'(c); req0_y2 = 9'(d);
    end else begin
      req1_start = 1; req1_x1 = 10'(a); req1_y1 = 9'(b); req1_x2 = 10'(c); req1_y2 = 9'(d);
    end
  endtask

  task automatic drive_rand(int i);
    drive(i, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 639), $urandom_range(0, 479));
  endtask

  // One clock edge: update the model from the inputs present at the edge, then play the drawer.
  // A line issued at edge I pulses start after I and may complete from edge I+3 on;
  // a slot captured at edge C may be selected from edge C+2 on.
  task automatic step();
    bit done, e0, e1, c0, c1;
    int pick;
    @(posedge clk);
    n++;
    if (rst) begin
      mp[0] = 0; mp[1] = 0; mbusy = 0; mlast = 1; missue = -100;
      ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0; eg = 0;
    end else begin
      done = mbusy && n >= missue + 3 && line_drawer_ready;
      e0 = mp[0] && n >= mcap[0] + 2;
      e1 = mp[1] && n >= mcap[1] + 2;
      pick = mbusy ? -1 : (e0 && e1) ? 1 - mlast : e0 ? 0 : e1 ? 1 : -1;
      c0 = req0_start && !mp[0];
      c1 = req1_start && !mp[1];
      if (done) begin mbusy = 0; mp[mcur] = 0; mlast = mcur; end
      if (pick >= 0) begin
        mbusy = 1; mcur = pick; missue = n; eg = pick[0];
        ex1 = mx1[pick]; ey1 = my1[pick]; ex2 = mx2[pick]; ey2 = my2[pick];
      end
      if (c0) begin mp[0] = 1; mcap[0] = n; mx1[0] = req0_x1; my1[0] = req0_y1; mx2[0] = req0_x2; my2[0] = req0_y2; end
      if (c1) begin mp[1] = 1; mcap[1] = n; mx1[1] = req1_x1; my1[1] = req1_y1; mx2[1] = req1_x2; my2[1] = req1_y2; end
    end
    expv = {mbusy && missue == n, !mp[1], !mp[0], eg, ex1, ey1, ex2, ey2};
    #1;
    req0_start = 0;
    req1_start = 0;
    if (rst) begin line_drawer_ready = 1; dcnt = 0; end
    else if (line_drawer_start) begin
      line_drawer_ready = 0;
      dcnt = dhold > 0 ? dhold : $urandom_range(1, 6);
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) line_drawer_ready = 1;
    end
  endtask

  task automatic apply_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 38'd0}) begin
      errors++; $display("FAIL reset: got %h want %h", obs, {1'b0, 1'b1, 1'b1, 1'b0, 38'd0});
    end
  endtask

  task automatic test_single();
    int e, s;
    apply_reset();
    dhold = 3;
    drive(0, 0, 240, 8, 236);
    step();
    e = n; s = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL single cyc %0d: got %h want %h", n, obs, expv); end
      if (line_drawer_start && s < 0) s = n;
    end
    checks++;
    if (s - e != 2) begin errors++; $display("FAIL single latency: got %0d want 2", s - e); end
  endtask

  task automatic test_both();
    int g [$];
    apply_reset();
    dhold = 2;
    drive_rand(0);
    drive_rand(1);
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL both cyc %0d: got %h want %h", n, obs, expv); end
      if (line_drawer_start) g.push_back(int'(grant));
    end
    checks++;
    if (g.size() != 2 || g[0] != 0 || g[1] != 1) begin
      errors++; $display("FAIL both order: got %0d pulses want 2 in order 0,1", g.size());
    end
  endtask

  task automatic test_back_to_back();
    int sent [2];
    int pulses, prev;
    apply_reset();
    dhold = 0;
    sent[0] = 0; sent[1] = 0; pulses = 0; prev = -1;
    for (int i = 0; i < 600 && pulses < 16; i++) begin
      for (int r = 0; r < 2; r++)
        if (!mp[r] && sent[r] < 8) begin drive_rand(r); sent[r]++; end
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL b2b cyc %0d: got %h want %h", n, obs, expv); end
      if (line_drawer_start) begin
        checks++;
        if (prev >= 0 && int'(grant) == prev) begin errors++; $display("FAIL b2b alternate: got %0d want %0d", grant, 1 - prev); end
        prev = int'(grant);
        pulses++;
      end
    end
    checks++;
    if (pulses != 16) begin errors++; $display("FAIL b2b pulses: got %0d want 16", pulses); end
  endtask

  task automatic test_drop_busy();
    int pulses;
    apply_reset();
    dhold = 4;
    pulses = 0;
    drive(0, 0, 0, 8, 8);
    step();
    drive(0, 16, 16, 24, 24);
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL drop cyc %0d: got %h want %h", n, obs, expv); end
      if (line_drawer_start) begin
        pulses++;
        checks++;
        if ({x1, y1, x2, y2} !== {10'd0, 9'd0, 10'd8, 9'd8}) begin
          errors++; $display("FAIL drop line: got %0d,%0d-%0d,%0d want 0,0-8,8", x1, y1, x2, y2);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL drop pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_long_hold();
    logic [38:0] held;
    bit seen;
    apply_reset();
    dhold = 100;
    seen = 0;
    drive_rand(1);
    for (int i = 0; i < 120; i++) begin
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL hold cyc %0d: got %h want %h", n, obs, expv); end
      if (seen) begin
        checks++;
        if ({grant, x1, y1, x2, y2} !== held || line_drawer_start !== 1'b0) begin
          errors++; $display("FAIL hold stable cyc %0d: got %h want %h", n, {grant, x1, y1, x2, y2}, held);
        end
      end
      if (line_drawer_start && !seen) begin seen = 1; held = {grant, x1, y1, x2, y2}; end
    end
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold release: got %b want 1", req1_ready); end
  endtask

  task automatic test_reset_mid();
    bit reached;
    apply_reset();
    dhold = 200;
    reached = 0;
    drive_rand(0);
    drive_rand(1);
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      reached = mbusy && n >= missue + 3 && mp[0] && mp[1];
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL rstmid setup: got no WAIT_2 want WAIT_2 with both pending"); end
    apply_reset();
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 38'd0}) begin
      errors++; $display("FAIL rstmid: got %h want %h", obs, {1'b0, 1'b1, 1'b1, 1'b0, 38'd0});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== expv || line_drawer_start !== 1'b0) begin
        errors++; $display("FAIL rstmid quiet cyc %0d: got %h want %h", n, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    dhold = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) drive_rand(0);
      if ($urandom_range(0, 3) == 0) drive_rand(1);
      step();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random cyc %0d: got %h want %h", n, obs, expv); end
    end
  endtask

  initial begin
    mlast = 1; mbusy = 0; missue = -100; mcur = 0;
    mcap[0] = 0; mcap[1] = 0;
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_drop_busy();
    test_long_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
